// File: rtl/echip_clk_pkg.sv
// Shared definitions for the on-chip clock monitor.
//   - state_t      : monitor FSM states
//   - DEF_PAT_*    : default 16-slot clock patterns (bit i = value at slot i)
//   - BIT_*        : clock-vector bit positions, shared with the clock generator
//   - expected_vec : expected {sclk, phi1F, phi2, phi1} vector at a given slot
package echip_clk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_LOCKING = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [15:0] DEF_PAT_PHI1  = 16'h00FE;
    localparam logic [15:0] DEF_PAT_PHI2  = 16'hFE00;
    localparam logic [15:0] DEF_PAT_PHI1F = 16'hFF00;
    localparam logic [15:0] DEF_PAT_SCLK  = 16'hFF00;
    localparam int          DEF_ALIGN_IDX    = 8;
    localparam int          DEF_LOCK_PERIODS = 4;

    localparam int BIT_PHI1  = 0;
    localparam int BIT_PHI2  = 1;
    localparam int BIT_PHI1F = 2;
    localparam int BIT_SCLK  = 3;

    function automatic logic [3:0] expected_vec(
        input logic [15:0] pat_phi1,
        input logic [15:0] pat_phi2,
        input logic [15:0] pat_phi1f,
        input logic [15:0] pat_sclk,
        input logic [3:0]  slot
    );
        logic [3:0] v;
        v            = '0;
        v[BIT_PHI1]  = pat_phi1[slot];
        v[BIT_PHI2]  = pat_phi2[slot];
        v[BIT_PHI1F] = pat_phi1f[slot];
        v[BIT_SCLK]  = pat_sclk[slot];
        return v;
    endfunction

endpackage

// File: rtl/echip_clk_monitor_sampler.sv
// Input stage of the clock monitor.
//   clk, rst           : serializer clock, synchronous active-high reset
//   phi1, phi2, phi1F,
//   sclk               : monitored clocks (synchronous to clk)
//   s_q_o              : registered clock vector {sclk, phi1F, phi2, phi1}
//   sclk_rise          : s_q.sclk = 1 while the previous sample had sclk = 0
//   overlap            : phi1 and phi2 both high in s_q
module echip_clk_sampler
    import echip_clk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       phi1,
    input  logic       phi2,
    input  logic       phi1F,
    input  logic       sclk,
    output logic [3:0] s_q_o,
    output logic       sclk_rise,
    output logic       overlap
);

    logic [3:0] s_d, s_q;
    logic [3:0] s_qq_d, s_qq;

    always_comb begin
        s_d            = '0;
        s_d[BIT_PHI1]  = phi1;
        s_d[BIT_PHI2]  = phi2;
        s_d[BIT_PHI1F] = phi1F;
        s_d[BIT_SCLK]  = sclk;
        s_qq_d         = s_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= '0;
            s_qq <= '0;
        end else begin
            s_q  <= s_d;
            s_qq <= s_qq_d;
        end
    end

    assign s_q_o     = s_q;
    assign sclk_rise = s_q[BIT_SCLK] & ~s_qq[BIT_SCLK];
    assign overlap   = s_q[BIT_PHI1] & s_q[BIT_PHI2];

endmodule

// File: rtl/echip_clk_monitor.sv
// Clock pattern monitor for phi1/phi2/phi1F/sclk.
//   clk, rst      : 81.92 MHz serializer clock, synchronous active-high reset
//   enable        : low forces IDLE (sticky flags and err_count kept)
//   clear_fault   : pulse; leaves FAULT, clears err_mask and overlap_err
//   phi1..sclk    : monitored clocks
//   locked, fault : state indicators
//   overlap_err   : sticky phi1/phi2 overlap flag
//   err_mask      : {sclk, phi1F, phi2, phi1} mismatch bits at FAULT entry
//   err_count     : saturating FAULT entry count (rst only clears it)
//   phase         : current slot (0 outside LOCKING/LOCKED)
//   period_strobe : high while LOCKED and phase is 15
module echip_clk_monitor
    import echip_clk_pkg::*;
#(
    parameter logic [15:0] PAT_PHI1     = DEF_PAT_PHI1,
    parameter logic [15:0] PAT_PHI2     = DEF_PAT_PHI2,
    parameter logic [15:0] PAT_PHI1F    = DEF_PAT_PHI1F,
    parameter logic [15:0] PAT_SCLK     = DEF_PAT_SCLK,
    parameter int          ALIGN_IDX    = DEF_ALIGN_IDX,
    parameter int          LOCK_PERIODS = DEF_LOCK_PERIODS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear_fault,
    input  logic       phi1,
    input  logic       phi2,
    input  logic       phi1F,
    input  logic       sclk,
    output logic       locked,
    output logic       fault,
    output logic       overlap_err,
    output logic [3:0] err_mask,
    output logic [7:0] err_count,
    output logic [3:0] phase,
    output logic       period_strobe
);

    // Slot following the sclk rise: the sample that aligned us is slot ALIGN_IDX,
    // so the next sample to be compared is ALIGN_IDX + 1.
    localparam logic [3:0] ALIGN_NEXT  = 4'((ALIGN_IDX + 1) % 16);
    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_PERIODS);

    logic [3:0] s_q;
    logic       sclk_rise;
    logic       overlap_now;

    echip_clk_sampler u_sampler (
        .clk       (clk),
        .rst       (rst),
        .phi1      (phi1),
        .phi2      (phi2),
        .phi1F     (phi1F),
        .sclk      (sclk),
        .s_q_o     (s_q),
        .sclk_rise (sclk_rise),
        .overlap   (overlap_now)
    );

    state_t     state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic [3:0] period_cnt_q, period_cnt_d;
    logic [3:0] err_mask_q, err_mask_d;
    logic [7:0] err_count_q, err_count_d;
    logic       locked_q, locked_d;
    logic       fault_q, fault_d;
    logic       overlap_err_q, overlap_err_d;
    logic       period_strobe_q, period_strobe_d;

    logic [3:0] exp_vec;
    logic [3:0] mism_vec;
    logic       mismatch;

    // phase_q always names the slot held in s_q, so the compare is same-cycle.
    assign exp_vec  = expected_vec(PAT_PHI1, PAT_PHI2, PAT_PHI1F, PAT_SCLK, phase_q);
    assign mism_vec = s_q ^ exp_vec;
    assign mismatch = |mism_vec;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and slot/period/error bookkeeping
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        period_cnt_d = period_cnt_q;
        err_mask_d   = err_mask_q;
        err_count_d  = err_count_q;

        if (!enable) begin
            state_d = ST_IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                    phase_d = '0;
                end
                ST_SEARCH: begin
                    phase_d = '0;
                    if (sclk_rise) begin
                        state_d      = ST_LOCKING;
                        phase_d      = ALIGN_NEXT;
                        period_cnt_d = '0;
                    end
                end
                ST_LOCKING: begin
                    if (mismatch) begin
                        state_d = ST_SEARCH;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 4'd1;
                        // The partial first period ends here too and counts.
                        if (phase_q == 4'd15) begin
                            period_cnt_d = period_cnt_q + 4'd1;
                            if ((period_cnt_q + 4'd1) == LOCK_TARGET) begin
                                state_d = ST_LOCKED;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (mismatch) begin
                        state_d    = ST_FAULT;
                        phase_d    = '0;
                        err_mask_d = mism_vec;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
                ST_FAULT: begin
                    phase_d = '0;
                    if (clear_fault) begin
                        state_d    = ST_SEARCH;
                        err_mask_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    // Outputs, registered from the next state so they line up with state_q
    always_comb begin
        locked_d        = (state_d == ST_LOCKED);
        fault_d         = (state_d == ST_FAULT);
        period_strobe_d = (state_d == ST_LOCKED) && (phase_d == 4'd15);
        // clear_fault beats a coincident overlap; the next offending sample re-sets it.
        overlap_err_d   = clear_fault ? 1'b0 : (overlap_err_q | overlap_now);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q         <= '0;
            period_cnt_q    <= '0;
            err_mask_q      <= '0;
            err_count_q     <= '0;
            locked_q        <= 1'b0;
            fault_q         <= 1'b0;
            overlap_err_q   <= 1'b0;
            period_strobe_q <= 1'b0;
        end else begin
            phase_q         <= phase_d;
            period_cnt_q    <= period_cnt_d;
            err_mask_q      <= err_mask_d;
            err_count_q     <= err_count_d;
            locked_q        <= locked_d;
            fault_q         <= fault_d;
            overlap_err_q   <= overlap_err_d;
            period_strobe_q <= period_strobe_d;
        end
    end

    assign locked        = locked_q;
    assign fault         = fault_q;
    assign overlap_err   = overlap_err_q;
    assign err_mask      = err_mask_q;
    assign err_count     = err_count_q;
    assign phase         = phase_q;
    assign period_strobe = period_strobe_q;

endmodule
